// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between
// the fetch port and the load/store port (4-cycle access sequence).
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             busy,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  if (SIZE < 1) begin : g_bad_size
    $error("mem_arbiter: SIZE must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // last_grant / current grant: 0 = fetch port, 1 = data port
  logic r_last_d;
  logic w_last_d_nx;
  logic r_gnt_d;
  logic w_gnt_d_nx;
  logic r_rd;
  logic w_rd_nx;

  logic [WIDTH-1:0] r_i_rdata;
  logic [WIDTH-1:0] w_i_rdata_nx;
  logic [WIDTH-1:0] r_d_rdata;
  logic [WIDTH-1:0] w_d_rdata_nx;
  logic             r_i_ack;
  logic             w_i_ack_nx;
  logic             r_d_ack;
  logic             w_d_ack_nx;
  logic             r_busy;
  logic             w_busy_nx;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] w_mem_addr_nx;
  logic             r_mem_cs;
  logic             w_mem_cs_nx;
  logic             r_mem_we;
  logic             w_mem_we_nx;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [WIDTH-1:0] w_mem_wdata_nx;

  logic w_pick_d;
  logic w_pick_rd;

  // On contention the port that did not win last time is served.
  assign w_pick_d  = d_req & (~i_req | ~r_last_d);
  assign w_pick_rd = ~(w_pick_d & d_we);

  always_comb begin
    w_state_nx     = r_state;
    w_last_d_nx    = r_last_d;
    w_gnt_d_nx     = r_gnt_d;
    w_rd_nx        = r_rd;
    w_i_rdata_nx   = r_i_rdata;
    w_d_rdata_nx   = r_d_rdata;
    w_i_ack_nx     = 1'b0;
    w_d_ack_nx     = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_cs_nx    = r_mem_cs;
    w_mem_we_nx    = r_mem_we;
    w_mem_wdata_nx = r_mem_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (i_req | d_req) begin
          w_state_nx    = S_ISSUE;
          w_gnt_d_nx    = w_pick_d;
          w_last_d_nx   = w_pick_d;
          w_rd_nx       = w_pick_rd;
          w_mem_addr_nx = w_pick_d ? d_addr : i_addr;
          w_mem_cs_nx   = w_pick_rd;
          w_mem_we_nx   = ~w_pick_rd;
          if (!w_pick_rd) begin
            w_mem_wdata_nx = d_wdata;
          end
        end
      end
      S_ISSUE: begin
        w_state_nx  = S_CAPTURE;
        w_mem_cs_nx = 1'b0;
        w_mem_we_nx = 1'b0;
      end
      S_CAPTURE: begin
        w_state_nx = S_RESP;
        if (r_gnt_d) begin
          w_d_ack_nx = 1'b1;
          if (r_rd) begin
            w_d_rdata_nx = mem_rdata;
          end
        end else begin
          w_i_ack_nx = 1'b1;
          if (r_rd) begin
            w_i_rdata_nx = mem_rdata;
          end
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_gnt_d     <= 1'b0;
      r_rd        <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_last_d    <= w_last_d_nx;
      r_gnt_d     <= w_gnt_d_nx;
      r_rd        <= w_rd_nx;
      r_i_rdata   <= w_i_rdata_nx;
      r_d_rdata   <= w_d_rdata_nx;
      r_i_ack     <= w_i_ack_nx;
      r_d_ack     <= w_d_ack_nx;
      r_busy      <= w_busy_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_cs    <= w_mem_cs_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_wdata <= w_mem_wdata_nx;
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_ack     = r_i_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized
// two-requester run against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] mem [0:1023];

  mem_arbiter #(.WIDTH(32), .SIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .busy(busy),
    .mem_addr(mem_addr), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory, registered read data.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_cs) mem_rdata <= mem[mem_addr[11:2]];
    else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = idx[9:0];
    pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL reset_i_ack: got %b want 0", i_ack); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack: got %b want 0", d_ack); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs: got %b want 0", mem_cs); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    i_req = 1'b1;
    i_addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (busy !== (k <= 3)) begin errors++; $display("FAIL fetch_busy c%0d: got %b want %b", k, busy, (k <= 3)); end
      checks++; if (i_ack !== (k == 3)) begin errors++; $display("FAIL fetch_ack c%0d: got %b want %b", k, i_ack, (k == 3)); end
      if (k == 1) begin
        checks++; if (mem_cs !== 1'b1) begin errors++; $display("FAIL fetch_cs: got %b want 1", mem_cs); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr: got %h want 10", mem_addr); end
      end
      if (k == 3) begin
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'h12345678;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (d_ack !== (k == 3 || k == 7)) begin errors++; $display("FAIL wr_d_ack c%0d: got %b want %b", k, d_ack, (k == 3 || k == 7)); end
      checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL wr_i_ack c%0d: got %b want 0", k, i_ack); end
      if (k == 1) begin
        checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL wr_cs: got %b want 0", mem_cs); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL wr_addr: got %h want 20", mem_addr); end
        checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata: got %h want 12345678", mem_wdata); end
      end
      if (k == 3) begin
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_hold: got %h want 0", d_rdata); end
        d_we = 1'b0;
      end
      if (k == 5) begin
        checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_cs_we: got %b%b want 10", mem_cs, mem_we); end
      end
      if (k == 7) begin
        checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_back: got %h want 12345678", d_rdata); end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention;
    rst = 1'b1;
    i_req = 1'b1;
    i_addr = 32'h10;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h20;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++; if (d_ack !== (k == 3 || k == 11)) begin errors++; $display("FAIL rr_d_ack c%0d: got %b want %b", k, d_ack, (k == 3 || k == 11)); end
      checks++; if (i_ack !== (k == 7 || k == 15)) begin errors++; $display("FAIL rr_i_ack c%0d: got %b want %b", k, i_ack, (k == 7 || k == 15)); end
      if (k == 3) begin
        checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL rr_d_rdata: got %h want 12345678", d_rdata); end
      end
      if (k == 7) begin
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_i_rdata: got %h want deadbeef", i_rdata); end
      end
      if (k == 15) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", busy); end
  endtask

  task automatic test_d_stream;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++; if (d_ack !== (k % 4 == 3)) begin errors++; $display("FAIL ds_d_ack c%0d: got %b want %b", k, d_ack, (k % 4 == 3)); end
      checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL ds_i_ack c%0d: got %b want 0", k, i_ack); end
      if (k == 11) begin
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ds_rdata: got %h want deadbeef", d_rdata); end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_rst_issue;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h40;
    d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_cs !== 1'b0) begin errors++; $display("FAIL ri_issue: got cs%b we%b want cs0 we1", mem_cs, mem_we); end
    rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (d_ack !== 1'b0 || i_ack !== 1'b0) begin errors++; $display("FAIL ri_ack: got %b%b want 00", i_ack, d_ack); end
    checks++; if (mem_cs !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL ri_cs_we: got %b%b want 00", mem_cs, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL ri_mem: got %h/%h want 0/0", mem_addr, mem_wdata); end
    checks++; if (d_rdata !== 32'h0 || i_rdata !== 32'h0) begin errors++; $display("FAIL ri_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ri_busy: got %b want 0", busy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL ri_no_ack c%0d: got %b want 0", k, d_ack); end
    end
    d_req = 1'b1;
    d_we = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL ri_read_ack: got %b want 1", d_ack); end
    checks++; if (d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ri_read_data: got %h want cafef00d", d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_capture;
    i_req = 1'b1;
    i_addr = 32'h10;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL rc_ack: got %b want 0", i_ack); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL rc_rdata: got %h want 0", i_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rc_busy: got %b want 0", busy); end
    @(negedge clk);
    checks++; if (i_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rc_after: got ack%b busy%b want 0/0", i_ack, busy); end
  endtask

  // Transaction-level model: each grant takes 4 cycles, ack on the
  // 4th, contention alternates away from the previous winner.
  task automatic test_random;
    logic [31:0] ref_mem [16];
    bit          ip, dp, dwe, last_d, ack_d, g_rd, pick_d;
    logic [31:0] ia, da, dw, g_addr, g_wd, g_rdv, ei, ed;
    int          idle_at, ack_at, iss_at;
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      ref_mem[j] = $urandom;
      preload(j, ref_mem[j]);
    end
    rst = 1'b0;
    ip = 0; dp = 0; dwe = 0; last_d = 0; ack_d = 0; g_rd = 0;
    ia = 0; da = 0; dw = 0; g_addr = 0; g_wd = 0; g_rdv = 0;
    ei = 0; ed = 0;
    idle_at = 0; ack_at = -1; iss_at = -1;
    for (int c = 0; c < 400; c++) begin
      if (c == ack_at && g_rd) begin
        if (ack_d) ed = g_rdv;
        else ei = g_rdv;
      end
      checks++; if (i_ack !== (c == ack_at && !ack_d)) begin errors++; $display("FAIL rnd_i_ack c%0d: got %b want %b", c, i_ack, (c == ack_at && !ack_d)); end
      checks++; if (d_ack !== (c == ack_at && ack_d)) begin errors++; $display("FAIL rnd_d_ack c%0d: got %b want %b", c, d_ack, (c == ack_at && ack_d)); end
      checks++; if (busy !== (c != idle_at)) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, (c != idle_at)); end
      checks++; if (i_rdata !== ei) begin errors++; $display("FAIL rnd_i_rdata c%0d: got %h want %h", c, i_rdata, ei); end
      checks++; if (d_rdata !== ed) begin errors++; $display("FAIL rnd_d_rdata c%0d: got %h want %h", c, d_rdata, ed); end
      if (c == iss_at) begin
        checks++; if (mem_cs !== g_rd || mem_we !== !g_rd) begin errors++; $display("FAIL rnd_op c%0d: got cs%b we%b want cs%b", c, mem_cs, mem_we, g_rd); end
        checks++; if (mem_addr !== g_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, g_addr); end
        if (!g_rd) begin
          checks++; if (mem_wdata !== g_wd) begin errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, g_wd); end
        end
      end
      if (c == ack_at) begin
        if (ack_d) dp = 0;
        else ip = 0;
      end
      if (!ip && $urandom_range(1, 0) == 1) begin
        ip = 1;
        ia = {26'h0, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
      end
      if (!dp && $urandom_range(1, 0) == 1) begin
        dp = 1;
        dwe = $urandom_range(1, 0) == 1;
        da = {26'h0, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
        dw = $urandom;
      end
      i_req = ip;
      i_addr = ia;
      d_req = dp;
      d_we = dwe;
      d_addr = da;
      d_wdata = dw;
      if (c == idle_at) begin
        if (ip || dp) begin
          pick_d = dp && (!ip || !last_d);
          last_d = pick_d;
          ack_d = pick_d;
          g_addr = pick_d ? da : ia;
          g_rd = !(pick_d && dwe);
          g_wd = dw;
          if (g_rd) g_rdv = ref_mem[g_addr[5:2]];
          else ref_mem[g_addr[5:2]] = dw;
          iss_at = c + 1;
          ack_at = c + 3;
          idle_at = c + 4;
        end else begin
          idle_at = c + 1;
        end
      end
      @(negedge clk);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0;
    i_addr = 32'h0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = 32'h0;
    d_wdata = 32'h0;
    pl_en = 1'b0;
    pl_idx = 10'h0;
    pl_val = 32'h0;
    preload(4, 32'hDEADBEEF);
    test_reset;
    test_fetch;
    test_write_read;
    test_contention;
    test_d_stream;
    test_rst_issue;
    test_rst_capture;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
